serial_addsub: RTL and testbench

Parametrised multi-cycle serial adder/subtractor with an integrated digit counter and controller. It processes DIGIT bits per clock, LSB-first, and produces WIDTH-bit sum, carry-out and signed-overflow flags. It extends the existing wait/work/done control FSM with an internal counter, a subtract mode, a status handshake and an asynchronous reset. It sits between the operand registers and any consumer that needs low-area arithmetic.

---
 rtl/serial_addsub.sv | 127 ++++++++++++
 tb/tb_serial_addsub.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Serial adder/subtractor: processes DIGIT bits per cycle LSB-first under an
// IDLE/RUN/DONE controller, producing sum, carry-out and signed overflow.

module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [1:0]       STATE
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_addsub: WIDTH must be >= 2");
    end
    if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT:0]         dig_full;
    logic                   dig_co;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_nxt;
    logic                   ovf_nxt;

    always_comb begin
        dig_full = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
        dig_co   = dig_full[DIGIT];
        // New digit enters at the MSB end; after N digits acc holds the full sum.
        acc_cat  = {dig_full[DIGIT-1:0], acc_q} >> DIGIT;
        acc_nxt  = acc_cat[WIDTH-1:0];
        ovf_nxt  = (a_msb_q == b_msb_q) && (acc_nxt[WIDTH-1] != a_msb_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        a_sh_q  <= a;
                        b_sh_q  <= sub ? ~b : b;
                        acc_q   <= '0;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_sh_q  <= a_sh_q >> DIGIT;
                    b_sh_q  <= b_sh_q >> DIGIT;
                    acc_q   <= acc_nxt;
                    carry_q <= dig_co;
                    if (cnt_q == LAST) begin
                        // Wrap to zero so the counter never passes N-1.
                        cnt_q   <= '0;
                        sum_q   <= acc_nxt;
                        cout_q  <= dig_co;
                        ovf_q   <= ovf_nxt;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StDone: begin
                    if (!go) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
    assign STATE = state_q;
    assign busy  = (state_q == StRun);
    assign done  = (state_q == StDone);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8-bit/1-bit-digit and 16-bit/4-bit-digit instances.

module tb_serial_addsub;

    logic        clk;
    logic        rst;

    logic        go8, sub8;
    logic [7:0]  a8, b8, sum8;
    logic        cout8, ovf8, busy8, done8;
    logic [1:0]  state8;

    logic        go16, sub16;
    logic [15:0] a16, b16, sum16;
    logic        cout16, ovf16, busy16, done16;
    logic [1:0]  state16;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst), .go(go8), .sub(sub8), .a(a8), .b(b8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8), .STATE(state8)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .go(go16), .sub(sub16), .a(a16), .b(b16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16),
        .STATE(state16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an 8-bit op from IDLE, checks latency and result; optionally holds go in DONE.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic s, input logic [7:0] es, input logic ec, input logic eo,
                       input int hold);
        int cyc;
        check({tag, "_idle"}, 32'(state8), 32'd0);
        a8 = av; b8 = bv; sub8 = s; go8 = 1'b1;
        tick();
        check({tag, "_load_state"}, 32'(state8), 32'd1);
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        cyc = 0;
        while (state8 == 2'b01 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_run_cycles"}, 32'(cyc), 32'd8);
        check({tag, "_done_state"}, 32'(state8), 32'd2);
        check({tag, "_done"}, 32'(done8), 32'd1);
        check({tag, "_sum"}, 32'(sum8), 32'(es));
        check({tag, "_cout"}, 32'(cout8), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_state"}, 32'(state8), 32'd2);
        end
        go8 = 1'b0;
        tick();
        check({tag, "_back_idle"}, 32'(state8), 32'd0);
        check({tag, "_done_low"}, 32'(done8), 32'd0);
        check({tag, "_sum_held"}, 32'(sum8), 32'(es));
    endtask

    task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input logic [15:0] es, input logic ec, input logic eo);
        int cyc;
        a16 = av; b16 = bv; sub16 = s; go16 = 1'b1;
        tick();
        check({tag, "_load_state"}, 32'(state16), 32'd1);
        cyc = 0;
        while (state16 == 2'b01 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_run_cycles"}, 32'(cyc), 32'd4);
        check({tag, "_done"}, 32'(done16), 32'd1);
        check({tag, "_sum"}, 32'(sum16), 32'(es));
        check({tag, "_cout"}, 32'(cout16), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf16), 32'(eo));
        go16 = 1'b0;
        tick();
        check({tag, "_back_idle"}, 32'(state16), 32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        go8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        go16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        #2;
        check("rst_state", 32'(state8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_busy_done", 32'({busy8, done8, cout8, ovf8}), 32'd0);
        #10;
        rst = 1'b1;
        tick();

        op8("add_basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
        op8("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        op8("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        op8("sub_borrow", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        op8("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        op8("hold_go", 8'h21, 8'h10, 1'b0, 8'h31, 1'b0, 1'b0, 5);

        // Inputs change and go drops mid-RUN; result and schedule unaffected.
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; go8 = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; go8 = 1'b0;
        cyc = 3;
        while (state8 == 2'b01 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("midrun_cycles", 32'(cyc), 32'd8);
        check("midrun_done", 32'(done8), 32'd1);
        check("midrun_sum", 32'(sum8), 32'h30);
        tick();
        check("midrun_idle", 32'(state8), 32'd0);

        // Async reset at RUN count 3, between edges.
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; go8 = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", 32'(state8), 32'd0);
        check("arst_outs", 32'({sum8, cout8, ovf8, busy8, done8}), 32'd0);
        a8 = 8'h40; b8 = 8'h02; sub8 = 1'b1;
        #1;
        rst = 1'b1;
        tick();
        check("arst_reload", 32'(state8), 32'd1);
        cyc = 0;
        while (state8 == 2'b01 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("arst_cycles", 32'(cyc), 32'd8);
        check("arst_sum", 32'(sum8), 32'h3E);
        check("arst_flags", 32'({cout8, ovf8}), 32'b10);
        go8 = 1'b0;
        tick();

        op16("w16_add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        op16("w16_sub", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
